flit_injector: RTL and testbench
================================

// Module: flit_injector
// PURPOSE
//  Transmit side of the per-VC flit link into input_port. Accepts packet descriptors
//  (VC, destination, head payload, length), serialises each into HEAD/BODY/TAIL or
//  HEADTAIL flits, and honours the receiver's per-VC on_off flow control.
//  Active VCs are arbitrated round-robin, one flit per cycle. Sits in the network
//  interface / traffic generator that feeds a router local port.
// PARAMETERS
//  MAX_PKT_SIZE  16  longest packet in flits; larger requests are clipped to this
//  SIZE_W        $clog2(MAX_PKT_SIZE)+1  width of pkt_size_i
//  (VC_NUM, VC_SIZE, DEST_ADDR_SIZE_X/Y, HEAD_PAYLOAD_SIZE, FLIT_DATA_SIZE, flit_t: noc_params)
// PORTS
//  clk            in   1                  clock, rising edge
//  rst            in   1                  reset, asynchronous, active-low
//  pkt_valid_i    in   1                  descriptor valid
//  pkt_ready_o    out  1                  descriptor accepted when valid&ready (= ~vc_busy_o[pkt_vc_i])
//  pkt_vc_i       in   VC_SIZE            target VC
//  pkt_x_dest_i   in   DEST_ADDR_SIZE_X   HEAD x_dest
//  pkt_y_dest_i   in   DEST_ADDR_SIZE_Y   HEAD y_dest
//  pkt_head_pl_i  in   HEAD_PAYLOAD_SIZE  HEAD head_pl
//  pkt_size_i     in   SIZE_W             packet length in flits
//  on_off_i       in   VC_NUM             per-VC permission from receiver; 1 = may send
//  data_o         out  flit_t             flit to receiver data_i
//  valid_flit_o   out  1                  data_o valid this cycle
//  vc_busy_o      out  VC_NUM             VC holds an unfinished packet
// BEHAVIOUR
//  - Reset (async, rst=0): valid_flit_o=0, data_o=0, vc_busy_o=0, rr ptr=0, all seq/idx=0;
//    partial packets abandoned, no TAIL emitted.
//  - Accept: at posedge with pkt_valid_i&pkt_ready_o, latch descriptor into VC slot,
//    vc_busy_o[vc]=1, idx=0. Size 0 -> 1; size > MAX_PKT_SIZE -> MAX_PKT_SIZE.
//  - Per-VC FSM: IDLE -(accept)-> SEND -(last flit granted)-> IDLE. Eligible = busy & on_off_i[vc].
//  - Arbiter: grant first eligible VC from rr ptr upward (mod VC_NUM); after a grant
//    rr = grant+1. No eligible VC -> valid_flit_o=0, data_o holds last value.
//  - Output registered: descriptor accepted at edge N -> HEAD visible after edge N+1 if on.
//  - Label: size 1 -> HEADTAIL; idx 0 -> HEAD; idx size-1 -> TAIL; else BODY. vc_id = VC.
//  - HEAD data = x_dest/y_dest/head_pl from descriptor. BODY/TAIL bt_pl: [7:0]=idx,
//    [15:8]=pkt_seq[vc], upper bits 0. FLIT_DATA_SIZE<16 is an elaboration error.
//  - pkt_seq[vc] 8-bit, +1 when TAIL/HEADTAIL granted, wraps 255->0.
//  - Last flit granted at edge M: vc_busy_o clears at M; pkt_ready_o for that VC high
//    in cycle after M; new HEAD earliest after edge M+2.
//  - on_off_i low mid-packet: VC paused, no flit for it while low; other VCs proceed;
//    flits of different VCs interleave, order within a VC preserved. on_off_i sampled
//    same cycle as grant (no internal pipelining).
//  - Descriptor to busy VC: pkt_ready_o=0, nothing latched, in-flight packet unaffected.
// CONFIGURATION
//  INJECTOR_STATS_EN defined: adds outputs flit_cnt_o[31:0] (+1 per valid flit) and
//  stall_cnt_o[31:0] (+1 per cycle with any busy VC but no grant); both reset to 0,
//  saturate at 2^32-1. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING  (VC_NUM=2, MAX_PKT_SIZE=16)
//  1 VC1 size 4, on_off=11 -> HEAD,BODY,BODY,TAIL consecutive, vc_id=1, bt_pl[7:0]=1,2,3, seq 0.
//  2 VC0 size 1 then size 0 -> two HEADTAILs, seq 0 then 1; second accepted in cycle after first sent.
//  3 VC0 size 3, VC1 size 3 next cycle -> H0,H1,B0,B1,T0,T1 alternating after first HEAD.
//  4 VC0 size 4, on_off[0]=0 for 3 cycles after HEAD -> valid_flit_o=0 3 cycles, then BODY idx1.
//  5 size 20 -> exactly 16 flits, TAIL idx 15; desc to busy VC held with pkt_ready_o=0.
//  6 rst low after 2 flits of size 8 -> valid_flit_o=0, vc_busy_o=0 immediately; new pkt seq 0.

Source files
------------

// File: rtl/flit_injector.sv
// Serialises packet descriptors into per-VC HEAD/BODY/TAIL/HEADTAIL flits under on/off flow control.
// Optional INJECTOR_STATS_EN adds saturating flit and stall counters.
module flit_injector #(
    parameter int VC_NUM            = 2,
    parameter int VC_SIZE           = $clog2(VC_NUM),
    parameter int DEST_ADDR_SIZE_X  = 2,
    parameter int DEST_ADDR_SIZE_Y  = 2,
    parameter int HEAD_PAYLOAD_SIZE = 16,
    parameter int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE,
    parameter int MAX_PKT_SIZE      = 16,
    parameter int SIZE_W            = $clog2(MAX_PKT_SIZE) + 1,
    parameter int FLIT_W            = 2 + VC_SIZE + FLIT_DATA_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [VC_SIZE-1:0]           pkt_vc_i,
    input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
    input  logic [SIZE_W-1:0]            pkt_size_i,
    input  logic [VC_NUM-1:0]            on_off_i,
    output logic [FLIT_W-1:0]            data_o,
    output logic                         valid_flit_o,
    output logic [VC_NUM-1:0]            vc_busy_o
`ifdef INJECTOR_STATS_EN
   ,output logic [31:0]                  flit_cnt_o,
    output logic [31:0]                  stall_cnt_o
`endif
);

    // Flit word layout: {label[1:0], vc_id, data}; HEAD data = {x_dest, y_dest, head_pl}.
    localparam logic [1:0] LBL_HEAD     = 2'd0;
    localparam logic [1:0] LBL_BODY     = 2'd1;
    localparam logic [1:0] LBL_TAIL     = 2'd2;
    localparam logic [1:0] LBL_HEADTAIL = 2'd3;

    typedef enum logic {IDLE, SEND} vc_state_t;

    generate
        if (FLIT_DATA_SIZE < 16) begin : g_width_check
            $error("flit_injector: FLIT_DATA_SIZE must be at least 16");
        end
    endgenerate

    logic [VC_NUM-1:0]              busy;
    logic [VC_NUM-1:0]              eligible;
    logic [VC_NUM-1:0][FLIT_W-1:0]  vc_flit;
    logic [VC_NUM-1:0]              vc_last;
    logic                           accept;
    logic [SIZE_W-1:0]              size_clip;
    logic                           grant_valid;
    logic [VC_SIZE-1:0]             grant;
    logic [VC_SIZE-1:0]             rr_reg;
    logic [VC_SIZE-1:0]             rr_next;

    assign pkt_ready_o = ~busy[pkt_vc_i];
    assign accept      = pkt_valid_i & pkt_ready_o;
    assign vc_busy_o   = busy;
    assign size_clip   = (pkt_size_i == '0)                       ? SIZE_W'(1) :
                         (pkt_size_i > SIZE_W'(MAX_PKT_SIZE))     ? SIZE_W'(MAX_PKT_SIZE) :
                                                                    pkt_size_i;

    genvar gi;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
            vc_state_t                    state_reg;
            logic [DEST_ADDR_SIZE_X-1:0]  x_reg;
            logic [DEST_ADDR_SIZE_Y-1:0]  y_reg;
            logic [HEAD_PAYLOAD_SIZE-1:0] pl_reg;
            logic [SIZE_W-1:0]            size_reg;
            logic [SIZE_W-1:0]            idx_reg;
            logic [7:0]                   seq_reg;
            logic [1:0]                   label;
            logic [FLIT_DATA_SIZE-1:0]    payload;

            assign busy[gi]     = (state_reg == SEND);
            assign eligible[gi] = busy[gi] & on_off_i[gi];
            assign vc_last[gi]  = (idx_reg == size_reg - 1'b1);
            assign label        = (size_reg == SIZE_W'(1)) ? LBL_HEADTAIL :
                                  (idx_reg == '0)          ? LBL_HEAD :
                                  vc_last[gi]              ? LBL_TAIL : LBL_BODY;
            assign payload      = (label == LBL_HEAD || label == LBL_HEADTAIL)
                                ? FLIT_DATA_SIZE'({x_reg, y_reg, pl_reg})
                                : FLIT_DATA_SIZE'({seq_reg, 8'(idx_reg)});
            assign vc_flit[gi]  = {label, VC_SIZE'(gi), payload};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= IDLE;
                    x_reg     <= '0;
                    y_reg     <= '0;
                    pl_reg    <= '0;
                    size_reg  <= '0;
                    idx_reg   <= '0;
                    seq_reg   <= '0;
                end else if (accept && pkt_vc_i == VC_SIZE'(gi)) begin
                    state_reg <= SEND;
                    x_reg     <= pkt_x_dest_i;
                    y_reg     <= pkt_y_dest_i;
                    pl_reg    <= pkt_head_pl_i;
                    size_reg  <= size_clip;
                    idx_reg   <= '0;
                end else if (grant_valid && grant == VC_SIZE'(gi)) begin
                    idx_reg <= idx_reg + 1'b1;
                    if (vc_last[gi]) begin
                        state_reg <= IDLE;
                        seq_reg   <= seq_reg + 8'd1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin: scan from rr_reg downward in offset so the smallest offset wins last.
    always_comb begin
        int cand;
        int nxt;
        grant_valid = 1'b0;
        grant       = '0;
        cand        = 0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            cand = int'(rr_reg) + i;
            if (cand >= VC_NUM) cand = cand - VC_NUM;
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant       = VC_SIZE'(cand);
            end
        end
        nxt = int'(grant) + 1;
        if (nxt >= VC_NUM) nxt = 0;
        rr_next = VC_SIZE'(nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o       <= '0;
            valid_flit_o <= 1'b0;
            rr_reg       <= '0;
        end else begin
            valid_flit_o <= grant_valid;
            if (grant_valid) begin
                data_o <= vc_flit[grant];
                rr_reg <= rr_next;
            end
        end
    end

`ifdef INJECTOR_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (grant_valid && flit_cnt_o != '1)
                flit_cnt_o <= flit_cnt_o + 32'd1;
            if ((|busy) && !grant_valid && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector (VC_NUM=2, MAX_PKT_SIZE=16) with hand-computed flit words.
module tb_flit_injector;

    localparam logic [1:0] L_HEAD     = 2'd0;
    localparam logic [1:0] L_BODY     = 2'd1;
    localparam logic [1:0] L_TAIL     = 2'd2;
    localparam logic [1:0] L_HEADTAIL = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [0:0]  pkt_vc_i;
    logic [1:0]  pkt_x_dest_i;
    logic [1:0]  pkt_y_dest_i;
    logic [15:0] pkt_head_pl_i;
    logic [4:0]  pkt_size_i;
    logic [1:0]  on_off_i;
    logic [22:0] data_o;
    logic        valid_flit_o;
    logic [1:0]  vc_busy_o;

    int vectors = 0;
    int miscompares = 0;

    flit_injector dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid_i   (pkt_valid_i),
        .pkt_ready_o   (pkt_ready_o),
        .pkt_vc_i      (pkt_vc_i),
        .pkt_x_dest_i  (pkt_x_dest_i),
        .pkt_y_dest_i  (pkt_y_dest_i),
        .pkt_head_pl_i (pkt_head_pl_i),
        .pkt_size_i    (pkt_size_i),
        .on_off_i      (on_off_i),
        .data_o        (data_o),
        .valid_flit_o  (valid_flit_o),
        .vc_busy_o     (vc_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [22:0] head_word(input logic [1:0] lbl, input logic vc,
                                              input logic [1:0] x, input logic [1:0] y,
                                              input logic [15:0] pl);
        return {lbl, vc, x, y, pl};
    endfunction

    function automatic logic [22:0] bt_word(input logic [1:0] lbl, input logic vc,
                                            input logic [7:0] seq, input logic [7:0] idx);
        return {lbl, vc, 4'b0000, seq, idx};
    endfunction

    task automatic expect_flit(input string tag, input logic [22:0] exp);
        check({tag, ".valid"}, 32'(valid_flit_o), 32'd1);
        check({tag, ".data"}, 32'(data_o), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_desc(input logic vc, input logic [1:0] x, input logic [1:0] y,
                            input logic [15:0] pl, input logic [4:0] size);
        pkt_valid_i   = 1'b1;
        pkt_vc_i      = vc;
        pkt_x_dest_i  = x;
        pkt_y_dest_i  = y;
        pkt_head_pl_i = pl;
        pkt_size_i    = size;
        #1;
        check("desc_ready", 32'(pkt_ready_o), 32'd1);
    endtask

    initial begin
        logic [22:0] held;
        rst           = 1'b0;
        pkt_valid_i   = 1'b0;
        pkt_vc_i      = '0;
        pkt_x_dest_i  = '0;
        pkt_y_dest_i  = '0;
        pkt_head_pl_i = '0;
        pkt_size_i    = '0;
        on_off_i      = 2'b11;

        repeat (2) step();
        check("rst.valid", 32'(valid_flit_o), 32'd0);
        check("rst.data", 32'(data_o), 32'd0);
        check("rst.busy", 32'(vc_busy_o), 32'd0);
        rst = 1'b1;
        step();

        // VC1 four-flit packet, continuous
        put_desc(1'b1, 2'd2, 2'd1, 16'hABCD, 5'd4);
        step();
        pkt_valid_i = 1'b0;
        check("t1.busy_set", 32'(vc_busy_o), 32'h2);
        step(); expect_flit("t1.head", head_word(L_HEAD, 1'b1, 2'd2, 2'd1, 16'hABCD));
        step(); expect_flit("t1.body1", bt_word(L_BODY, 1'b1, 8'd0, 8'd1));
        step(); expect_flit("t1.body2", bt_word(L_BODY, 1'b1, 8'd0, 8'd2));
        step(); expect_flit("t1.tail", bt_word(L_TAIL, 1'b1, 8'd0, 8'd3));
        check("t1.busy_clr", 32'(vc_busy_o), 32'd0);
        step();
        check("t1.idle", 32'(valid_flit_o), 32'd0);

        // VC0 size 1 then size 0 (clipped to 1)
        put_desc(1'b0, 2'd1, 2'd3, 16'h1111, 5'd1);
        step();
        pkt_valid_i = 1'b0;
        step(); expect_flit("t2.ht0", head_word(L_HEADTAIL, 1'b0, 2'd1, 2'd3, 16'h1111));
        check("t2.busy_clr", 32'(vc_busy_o), 32'd0);
        put_desc(1'b0, 2'd3, 2'd0, 16'h2222, 5'd0);
        step();
        pkt_valid_i = 1'b0;
        check("t2.gap", 32'(valid_flit_o), 32'd0);
        step(); expect_flit("t2.ht1", head_word(L_HEADTAIL, 1'b0, 2'd3, 2'd0, 16'h2222));

        // Two VCs interleaving; VC0 seq now 2, VC1 seq 1
        put_desc(1'b0, 2'd1, 2'd1, 16'h3333, 5'd3);
        step();
        put_desc(1'b1, 2'd2, 2'd2, 16'h4444, 5'd3);
        step();
        pkt_valid_i = 1'b0;
        expect_flit("t3.h0", head_word(L_HEAD, 1'b0, 2'd1, 2'd1, 16'h3333));
        step(); expect_flit("t3.h1", head_word(L_HEAD, 1'b1, 2'd2, 2'd2, 16'h4444));
        step(); expect_flit("t3.b0", bt_word(L_BODY, 1'b0, 8'd2, 8'd1));
        step(); expect_flit("t3.b1", bt_word(L_BODY, 1'b1, 8'd1, 8'd1));
        step(); expect_flit("t3.t0", bt_word(L_TAIL, 1'b0, 8'd2, 8'd2));
        step(); expect_flit("t3.t1", bt_word(L_TAIL, 1'b1, 8'd1, 8'd2));
        step();
        check("t3.idle", 32'(valid_flit_o), 32'd0);

        // on_off[0] low for three cycles after HEAD; data_o must hold
        put_desc(1'b0, 2'd0, 2'd0, 16'h5555, 5'd4);
        step();
        pkt_valid_i = 1'b0;
        step();
        held = head_word(L_HEAD, 1'b0, 2'd0, 2'd0, 16'h5555);
        expect_flit("t4.head", held);
        on_off_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4.paused", 32'(valid_flit_o), 32'd0);
            check("t4.hold", 32'(data_o), 32'(held));
        end
        on_off_i = 2'b11;
        step(); expect_flit("t4.body1", bt_word(L_BODY, 1'b0, 8'd3, 8'd1));
        step(); expect_flit("t4.body2", bt_word(L_BODY, 1'b0, 8'd3, 8'd2));
        step(); expect_flit("t4.tail", bt_word(L_TAIL, 1'b0, 8'd3, 8'd3));

        // Size 20 clipped to 16; descriptor to busy VC1 refused
        put_desc(1'b1, 2'd1, 2'd0, 16'h6666, 5'd20);
        step();
        pkt_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 0)
                expect_flit("t5.head", head_word(L_HEAD, 1'b1, 2'd1, 2'd0, 16'h6666));
            else if (i == 15)
                expect_flit("t5.tail", bt_word(L_TAIL, 1'b1, 8'd2, 8'd15));
            else
                expect_flit("t5.body", bt_word(L_BODY, 1'b1, 8'd2, 8'(i)));
            if (i >= 1 && i <= 4) begin
                pkt_valid_i   = 1'b1;
                pkt_vc_i      = 1'b1;
                pkt_head_pl_i = 16'h7777;
                pkt_size_i    = 5'd2;
                #1;
                check("t5.busy_refused", 32'(pkt_ready_o), 32'd0);
            end else begin
                pkt_valid_i = 1'b0;
            end
        end
        check("t5.busy_clr", 32'(vc_busy_o), 32'd0);
        step();
        check("t5.idle", 32'(valid_flit_o), 32'd0);
        check("t5.no_latch", 32'(vc_busy_o), 32'd0);

        // Asynchronous reset mid-packet
        put_desc(1'b0, 2'd2, 2'd2, 16'h8888, 5'd8);
        step();
        pkt_valid_i = 1'b0;
        step(); expect_flit("t6.head", head_word(L_HEAD, 1'b0, 2'd2, 2'd2, 16'h8888));
        step(); expect_flit("t6.body1", bt_word(L_BODY, 1'b0, 8'd4, 8'd1));
        rst = 1'b0;
        #1;
        check("t6.rst_valid", 32'(valid_flit_o), 32'd0);
        check("t6.rst_busy", 32'(vc_busy_o), 32'd0);
        check("t6.rst_data", 32'(data_o), 32'd0);
        #2;
        rst = 1'b1;
        step();
        put_desc(1'b0, 2'd1, 2'd2, 16'h9999, 5'd2);
        step();
        pkt_valid_i = 1'b0;
        step(); expect_flit("t6.new_head", head_word(L_HEAD, 1'b0, 2'd1, 2'd2, 16'h9999));
        step(); expect_flit("t6.new_tail", bt_word(L_TAIL, 1'b0, 8'd0, 8'd1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
